// File: rtl/instr_sequencer_if.sv
// Instruction/control bundle between the instruction source, the sequencer and the datapath.
interface instr_sequencer_if;
   logic [15:0] in;
   logic        load;
   logic        s;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        write;
   logic        vsel;
   logic        loada;
   logic        loadb;
   logic        loadc;
   logic        loads;
   logic        asel;
   logic        bsel;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic [15:0] sximm8;
   logic        err;

   modport master (
      output in, load, s,
      input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
             asel, bsel, shift, ALUop, sximm8, err
   );

   modport slave (
      input  in, load, s,
      output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
             asel, bsel, shift, ALUop, sximm8, err
   );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction register, decoder and Moore FSM sequencing the Simple RISC Machine datapath.
// Define SEQ_ILLEGAL_TRAP_EN to trap illegal instructions in a HALT state with err=1.
module instr_sequencer (
   input logic          clk,
   input logic          reset,
   instr_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      StWait, StDecode, StWrImm, StGetA, StGetB, StExec, StWrReg
`ifdef SEQ_ILLEGAL_TRAP_EN
      , StHalt
`endif
   } state_e;

   state_e      state_q;
   logic [15:0] ir_q;
   logic        w_q, write_q, vsel_q, loada_q, loadb_q, loadc_q, loads_q, asel_q;
   logic [2:0]  readnum_q, writenum_q;
   logic [1:0]  alu_op_q;

   logic [2:0] opcode, rn, rd, rm;
   logic [1:0] op;
   logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

   assign opcode     = ir_q[15:13];
   assign op         = ir_q[12:11];
   assign rn         = ir_q[10:8];
   assign rd         = ir_q[7:5];
   assign rm         = ir_q[2:0];
   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_cmp     = is_alu && (op == 2'b01);
   assign is_mvn     = is_alu && (op == 2'b11);

`ifdef SEQ_ILLEGAL_TRAP_EN
   logic err_q;
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   // Outputs are registered alongside the state so they always match the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StWait;
         ir_q       <= '0;
         w_q        <= 1'b1;
         readnum_q  <= '0;
         writenum_q <= '0;
         write_q    <= 1'b0;
         vsel_q     <= 1'b0;
         loada_q    <= 1'b0;
         loadb_q    <= 1'b0;
         loadc_q    <= 1'b0;
         loads_q    <= 1'b0;
         asel_q     <= 1'b0;
         alu_op_q   <= '0;
`ifdef SEQ_ILLEGAL_TRAP_EN
         err_q      <= 1'b0;
`endif
      end else begin
         w_q        <= 1'b0;
         readnum_q  <= '0;
         writenum_q <= '0;
         write_q    <= 1'b0;
         vsel_q     <= 1'b0;
         loada_q    <= 1'b0;
         loadb_q    <= 1'b0;
         loadc_q    <= 1'b0;
         loads_q    <= 1'b0;
         asel_q     <= 1'b0;
         alu_op_q   <= '0;
         case (state_q)
            StWait: begin
               if (bus.load) ir_q <= bus.in;
               if (bus.s) state_q <= StDecode;
               else       w_q     <= 1'b1;
            end
            StDecode: begin
               if (is_mov_imm) begin
                  state_q    <= StWrImm;
                  writenum_q <= rn;
                  vsel_q     <= 1'b1;
                  write_q    <= 1'b1;
               end else if (is_mov_reg || is_mvn) begin
                  state_q   <= StGetB;
                  readnum_q <= rm;
                  loadb_q   <= 1'b1;
               end else if (is_alu) begin
                  state_q   <= StGetA;
                  readnum_q <= rn;
                  loada_q   <= 1'b1;
               end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                  state_q <= StHalt;
                  err_q   <= 1'b1;
`else
                  state_q <= StWait;
                  w_q     <= 1'b1;
`endif
               end
            end
            StGetA: begin
               state_q   <= StGetB;
               readnum_q <= rm;
               loadb_q   <= 1'b1;
            end
            StGetB: begin
               state_q  <= StExec;
               alu_op_q <= is_alu ? op : 2'b00;
               asel_q   <= is_mov_reg || is_mvn;
               loads_q  <= is_cmp;
               loadc_q  <= !is_cmp;
            end
            StExec: begin
               if (is_cmp) begin
                  state_q <= StWait;
                  w_q     <= 1'b1;
               end else begin
                  state_q    <= StWrReg;
                  writenum_q <= rd;
                  write_q    <= 1'b1;
               end
            end
            StWrImm, StWrReg: begin
               state_q <= StWait;
               w_q     <= 1'b1;
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            StHalt: begin
               err_q <= 1'b1;
            end
`endif
            default: begin
               state_q <= StWait;
               w_q     <= 1'b1;
            end
         endcase
      end
   end

   assign bus.w        = w_q;
   assign bus.readnum  = readnum_q;
   assign bus.writenum = writenum_q;
   assign bus.write    = write_q;
   assign bus.vsel     = vsel_q;
   assign bus.loada    = loada_q;
   assign bus.loadb    = loadb_q;
   assign bus.loadc    = loadc_q;
   assign bus.loads    = loads_q;
   assign bus.asel     = asel_q;
   assign bus.bsel     = 1'b0;
   assign bus.ALUop    = alu_op_q;
   assign bus.shift    = ir_q[4:3];
   assign bus.sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction register, decoder and Moore state machine that sequences the Simple RISC Machine datapath (register file, A/B/C registers, shifter, 16-bit ALU, status register) one instruction at a time. It sits between the instruction source and the datapath. It latches a 16-bit instruction, waits for start, then drives the register numbers, load strobes, mux selects and ALUop for each step.

## Interface
- No parameters; widths fixed: 16-bit instruction, 3-bit register numbers.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- in  input  16  instruction word
- load  input  1  capture `in` into IR (honoured only in WAIT)
- s  input  1  start execution (honoured only in WAIT)
- w  output  1  high while in WAIT (idle, ready)
- readnum  output  3  register file read address
- writenum  output  3  register file write address
- write  output  1  register file write enable
- vsel  output  1  write-data select: 0 = C register, 1 = sximm8
- loada, loadb, loadc, loads  output  1 each  datapath register load strobes
- asel  output  1  1 forces ALU A input to 0
- bsel  output  1  fixed 0 (B path from shifter)
- shift  output  2  IR[4:3]
- ALUop  output  2  ALU function: 00 add, 01 sub, 10 and, 11 not-B
- sximm8  output  16  IR[7:0] sign-extended
- err  output  1  illegal-instruction trap flag

## Operation
- IR fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
- Legal instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD
  - 101/01 CMP
  - 101/10 AND
  - 101/11 MVN
- Any other opcode/op pair is illegal.
- States: WAIT, DECODE, WR_IMM, GET_A, GET_B, EXEC, WR_REG, HALT (HALT exists only with the trap macro).
- State transitions:
  - WAIT: s=1 → DECODE, otherwise stay in WAIT.
  - DECODE:
    - MOV imm → WR_IMM.
    - MOV reg and MVN → GET_B.
    - ADD, CMP and AND → GET_A.
    - Illegal → see Configuration.
  - GET_A → GET_B → EXEC.
  - EXEC: CMP → WAIT; all others → WR_REG.
  - WR_IMM and WR_REG → WAIT.
- Moore outputs per state; any output not listed for a state is 0:
  - WAIT: w=1.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - EXEC:
    - ALUop: op for the 101 group, 00 for MOV reg.
    - asel=1 for MOV reg and MVN.
    - CMP asserts loads=1 with loadc=0; all other instructions assert loadc=1 with loads=0.
  - WR_REG: writenum=Rd, vsel=0, write=1.
  - WR_IMM: writenum=Rn, vsel=1, write=1.
- Combinational outputs: shift and sximm8 follow IR at all times.
- load and s asserted outside WAIT are ignored; IR does not change during execution.

## Timing
- Reset values:
  - state WAIT, IR=0.
  - w=1, err=0.
  - All strobes, selects, readnum, writenum and ALUop are 0.
- Cycle 0 is the edge at which s is sampled high in WAIT.
- Latency in cycles after cycle 0:
  - MOV imm: write asserted in cycle 2; w=1 again in cycle 3.
  - MOV reg / MVN: GET_B in cycle 2, EXEC in 3, WR_REG in 4; w=1 in cycle 5.
  - ADD / AND: GET_A in cycle 2, GET_B in 3, EXEC in 4, WR_REG in 5; w=1 in cycle 6.
  - CMP: same as ADD through EXEC in cycle 4; w=1 in cycle 5; write is never asserted.
- load and s together in WAIT: IR captures `in` on that edge, and DECODE uses the new IR.
- Back-to-back: s held high through WAIT starts the next instruction immediately. WAIT lasts one cycle minimum.
- Reset in any state: the next cycle is WAIT with reset outputs. A write that has not yet occurred is abandoned. IR clears to 0.

## Configuration
- SEQ_ILLEGAL_TRAP_EN defined:
  - An illegal instruction in DECODE → HALT.
  - HALT: err=1, w=0, all strobes 0, s and load ignored; HALT exits only on reset.
- SEQ_ILLEGAL_TRAP_EN undefined:
  - An illegal instruction in DECODE → WAIT and is executed as a no-op.
  - err is tied to 0 and no HALT state is synthesised.

## Test plan
- MOV R0,#-5: load in=16'hD0FB, then s.
  - Expect sximm8=16'hFFFB in all cycles.
  - Cycle 2: writenum=0, vsel=1, write=1.
  - w=1 in cycle 3.
- ADD R2,R1,R0,LSL#1: load in=16'hA148, then s.
  - Cycle 2: readnum=1, loada=1.
  - Cycle 3: readnum=0, loadb=1, shift=01.
  - Cycle 4: ALUop=00, asel=0, loadc=1.
  - Cycle 5: writenum=2, write=1.
  - w=1 in cycle 6.
- CMP R1,R0: load in=16'hA900, then s.
  - Cycle 4: ALUop=01, loads=1, loadc=0.
  - write stays 0 throughout; w=1 in cycle 5.
- MVN R3,R4: load in=16'hB864, then s.
  - No loada pulse.
  - Cycle 2: readnum=4, loadb=1.
  - Cycle 3: asel=1, ALUop=11, loadc=1.
  - Cycle 4: writenum=3, write=1.
- Ignored inputs and reset:
  - During the ADD above, pulse load with in=16'hD0FB in cycle 2; IR stays 16'hA148.
  - Assert reset in cycle 3: next cycle w=1 and all outputs are 0; write is never asserted.
- Illegal instruction: load in=16'hE000, then s.
  - With SEQ_ILLEGAL_TRAP_EN: err=1 and w=0 from cycle 2; the state persists through a further s, and reset clears it.
  - Without the macro: w=1 in cycle 2 and err=0.
